// File: rtl/csa_acc_pkg.sv
// Shared types and elaboration helpers for the carry-save batch accumulator.
package csa_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/csa_acc_if.sv
// Operand stream, result handshake and flush for csa_accumulator.
interface csa_acc_if import csa_acc_pkg::*; #(
  parameter int N       = 32,
  parameter int MAX_OPS = 8
) ();
  localparam int G = clog2(MAX_OPS);
  localparam int W = N + G;

  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic [G:0]   out_count;
  logic         out_ovf;

  modport master (
    output flush, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  flush, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csa_row.sv
// One row of full-adder 3:2 cells: bitwise sum and majority, no carry ripple.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] maj
);
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign maj[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end
endmodule

// File: rtl/csa_accumulator.sv
// Batch accumulator: carry-save compression per operand, then a chunked
// carry-propagate resolve. Define CSA_ACC_SIGNED_EN for two's-complement operands.
module csa_accumulator import csa_acc_pkg::*; #(
  parameter int N       = 32,
  parameter int MAX_OPS = 8,
  parameter int CHUNK   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  csa_acc_if.slave  bus
);
  localparam int G  = clog2(MAX_OPS);
  localparam int W  = N + G;
  localparam int R  = ceil_div(W, CHUNK);
  localparam int RC = R * CHUNK;
  localparam int IW = clog2(R + 1);

  state_t         state;
  logic [W-1:0]   s_q, c_q, x, s_nx, maj, c_nx;
  logic [G:0]     cnt_q, cnt_nx;
  logic [RC-1:0]  sum_q, sum_nx;
  logic [CHUNK-1:0] s_lo, c_lo;
  logic [CHUNK:0] part;
  logic [IW-1:0]  idx_q;
  logic           cy_q, ovf_q, in_ready_q, out_valid_q;
  logic           acc, close;

`ifdef CSA_ACC_SIGNED_EN
  assign x = {{G{bus.in_data[N-1]}}, bus.in_data};
`else
  assign x = {{G{1'b0}}, bus.in_data};
`endif

  csa_row #(.W(W)) u_row (
    .a  (s_q),
    .b  (c_q),
    .c  (x),
    .s  (s_nx),
    .maj(maj)
  );

  // Carry word moves up one bit; the carry out of the MSB falls off.
  assign c_nx   = W'({maj, 1'b0});
  assign acc    = bus.in_valid && in_ready_q && !bus.flush;
  assign cnt_nx = cnt_q + 1'b1;
  assign close  = bus.in_last || (cnt_nx == (G+1)'(MAX_OPS));

  // Resolver consumes the low chunk of S/C each cycle and shifts the
  // finished chunk in from the top, so chunk 0 lands at bit 0 after R steps.
  assign s_lo   = CHUNK'(s_q);
  assign c_lo   = CHUNK'(c_q);
  assign part   = {1'b0, s_lo} + {1'b0, c_lo} + (CHUNK+1)'(cy_q);
  assign sum_nx = (sum_q >> CHUNK) | (RC'(part[CHUNK-1:0]) << (RC - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready_q <= 1'b1;
          if (acc) begin
            s_q   <= s_nx;
            c_q   <= c_nx;
            cnt_q <= cnt_nx;
            if (close) begin
              state      <= RESOLVE;
              in_ready_q <= 1'b0;
              ovf_q      <= !bus.in_last;
              idx_q      <= '0;
              cy_q       <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          sum_q <= sum_nx;
          s_q   <= s_q >> CHUNK;
          c_q   <= c_q >> CHUNK;
          cy_q  <= part[CHUNK];
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(R - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = W'(sum_q);
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule
